// File: rtl/adder_ctrl_pkg.sv
// Shared types and default sizing for the LIF adder timestep controller.
package adder_ctrl_pkg;

  localparam int unsigned FP_W              = 32;
  localparam int unsigned DEF_NUM_NEURONS   = 30;
  localparam int unsigned DEF_IDX_W         = 5;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SET,
    ST_FETCH,
    ST_WAIT_W,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adder_settle_timer.sv
// Loadable down-counter: expired_c goes high once SETTLE_CYCLES enabled cycles have elapsed since load.
module adder_settle_timer
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Load on entry, then count down to zero while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/adder_timestep_controller.sv
// Per-timestep sequencer for the combinational LIF potential adder.
module adder_timestep_controller
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned NUM_NEURONS   = DEF_NUM_NEURONS,
  parameter int unsigned IDX_W         = DEF_IDX_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   clear_adder,
  output logic                   set_adder,
  output logic [FP_W-1:0]        input_weight,
  output logic [FP_W-1:0]        decayed_potential,
  input  logic [FP_W-1:0]        final_potential,
  input  logic                   spike,
  output logic                   pot_rd_en,
  output logic [IDX_W-1:0]       pot_rd_addr,
  input  logic [FP_W-1:0]        pot_rd_data,
  output logic                   pot_wr_en,
  output logic [IDX_W-1:0]       pot_wr_addr,
  output logic [FP_W-1:0]        pot_wr_data,
  input  logic                   weight_valid,
  input  logic [FP_W-1:0]        weight_data,
  output logic                   weight_ready,
  output logic [NUM_NEURONS-1:0] spike_vec
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_pend_q;
  logic             settle_load, settle_en, settle_expired_c;

  adder_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (settle_load),
    .en        (settle_en),
    .expired_c (settle_expired_c)
  );

  // Next-state, neuron index and settle-timer control.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_load = 1'b0;
    settle_en   = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_SET;
        idx_d   = '0;
      end
      ST_SET:     state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_WAIT_W;
      ST_WAIT_W: begin
        if (weight_valid && weight_ready) begin
          state_d     = ST_SETTLE;
          settle_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        settle_en = 1'b1;
        if (settle_expired_c) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and index registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Control outputs registered from the next-state decode so they line up with the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      clear_adder  <= 1'b0;
      set_adder    <= 1'b0;
      pot_rd_en    <= 1'b0;
      weight_ready <= 1'b0;
      pot_wr_en    <= 1'b0;
      pot_rd_addr  <= '0;
      pot_wr_addr  <= '0;
    end else begin
      busy         <= (state_d != ST_IDLE);
      done         <= (state_d == ST_DONE);
      clear_adder  <= (state_d == ST_CLEAR);
      set_adder    <= (state_d == ST_SET);
      pot_rd_en    <= (state_d == ST_FETCH);
      weight_ready <= (state_d == ST_WAIT_W);
      pot_wr_en    <= (state_d == ST_CAPTURE);
      if (state_d == ST_FETCH)   pot_rd_addr <= idx_d;
      if (state_d == ST_CAPTURE) pot_wr_addr <= idx_q;
    end
  end

  // Operand capture, result capture and spike recording.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pend_q         <= 1'b0;
      decayed_potential <= '0;
      input_weight      <= '0;
      pot_wr_data       <= '0;
      spike_vec         <= '0;
    end else begin
      rd_pend_q <= (state_q == ST_FETCH);
      if ((state_q == ST_WAIT_W) && rd_pend_q) decayed_potential <= pot_rd_data;
      if ((state_q == ST_WAIT_W) && weight_valid && weight_ready) input_weight <= weight_data;
      if ((state_q == ST_IDLE) && start) spike_vec <= '0;
      if ((state_q == ST_SETTLE) && settle_expired_c) begin
        pot_wr_data <= final_potential;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
          if (idx_q == IDX_W'(i)) spike_vec[i] <= spike;
        end
      end
    end
  end

endmodule

// File: doc/adder_timestep_controller.md
# adder_timestep_controller

Timestep sequencer that drives the combinational LIF potential adder of the 30-neuron accelerator. Once per timestep it:
- pulses the adder's clear and set controls;
- walks every neuron index, presenting the neuron's decayed potential and its accumulated input weight;
- waits a fixed settle time, then writes the adder's final potential back to potential memory and records the spike bit.

It sits between the weight accumulator, the potential memory and the adder, and replaces the free-running clear/set/done counters used so far.

## Interface
- NUM_NEURONS, 30, neurons processed per timestep (≥1)
- IDX_W, 5, neuron index width, ≥ clog2(NUM_NEURONS)
- SETTLE_CYCLES, 4, cycles the adder inputs are held stable before sampling (≥1)

Ports:
- CLK  in  1  single clock; all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  begin a timestep; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- clear_adder  out  1  one-cycle clear pulse to adder
- set_adder  out  1  one-cycle set pulse to adder
- input_weight  out  32  IEEE-754 weight to adder
- decayed_potential  out  32  IEEE-754 decayed potential to adder
- final_potential  in  32  adder result
- spike  in  1  adder spike flag
- pot_rd_en  out  1  potential memory read strobe
- pot_rd_addr  out  IDX_W  read index
- pot_rd_data  in  32  read data, valid 1 cycle after pot_rd_en
- pot_wr_en  out  1  write strobe
- pot_wr_addr  out  IDX_W  write index
- pot_wr_data  out  32  write data
- weight_valid  in  1  weight for current index available
- weight_data  in  32  weight value
- weight_ready  out  1  high only in WAIT_W
- spike_vec  out  NUM_NEURONS  spike bit per neuron for the last timestep

## Operation
- States: IDLE, CLEAR, SET, FETCH, WAIT_W, SETTLE, CAPTURE, DONE.
- IDLE, start=1 → CLEAR. clear_adder=1 for this single cycle; spike_vec cleared to 0.
- CLEAR → SET. set_adder=1 for one cycle; this loads the adder's threshold/model. idx reset to 0.
- SET → FETCH. pot_rd_en=1, pot_rd_addr=idx.
- FETCH → WAIT_W.
  - pot_rd_data is captured into decayed_potential at the end of the first WAIT_W cycle.
  - weight_ready=1 throughout WAIT_W.
  - On weight_valid&&weight_ready, weight_data is registered into input_weight → SETTLE.
  - weight_valid low stalls indefinitely in WAIT_W; all outputs are held.
- SETTLE counts SETTLE_CYCLES cycles with adder inputs held.
  - At the end of the last SETTLE cycle, final_potential → pot_wr_data and spike → spike_vec[idx].
  - Then → CAPTURE.
- CAPTURE: pot_wr_en=1, pot_wr_addr=idx for exactly one cycle.
  - If idx==NUM_NEURONS-1 → DONE; else idx+1 → FETCH.
- DONE: done=1 for one cycle → IDLE. spike_vec holds until the next CLEAR.
- Arithmetic: none in this block. Values pass through bit-exact; idx never exceeds NUM_NEURONS-1.

## Timing
- All outputs are registered state decodes; none are combinational from inputs.
- Reset values: state IDLE, idx 0, every output 0 (including spike_vec, input_weight, decayed_potential, pot_wr_data).
- Per-neuron cost with weight_valid already high: FETCH 1 + WAIT_W 1 + SETTLE SETTLE_CYCLES + CAPTURE 1 = SETTLE_CYCLES+3.
- With start sampled at cycle t:
  - CLEAR at t+1, SET at t+2, first FETCH at t+3.
  - done at t+3+NUM_NEURONS·(SETTLE_CYCLES+3). Defaults give t+213.
- Boundary conditions:
  - start while busy: ignored; no restart.
  - start held high: a new timestep starts on the cycle after DONE's return to IDLE.
  - weight_valid already high on WAIT_W entry: transfer in the first WAIT_W cycle.
  - Input stability: input_weight and decayed_potential must not change during SETTLE.
  - Adder pulses: clear_adder and set_adder are never high simultaneously.
  - RESET_N low mid-timestep: immediate return to reset values. No partial write is completed, and pot_wr_en drops asynchronously.

## Structure
- Shared package adder_ctrl_pkg holds:
  - state enum;
  - FP_W=32;
  - default NUM_NEURONS and SETTLE_CYCLES constants, reused by the potential memory and accumulator.
- One natural sub-module: adder_settle_timer, a loadable down-counter that asserts expired after SETTLE_CYCLES.
- The potential adder itself is instantiated beside this block at the neuron-array top, not inside it.

## Test plan
- No spike: NUM_NEURONS=1, pot_rd_data=0x41F00000 (30.0), weight 0x3F800000 (1.0), adder model threshold 40.0.
  - Required: pot_wr_data=0x41F80000, spike_vec=0.
  - done at t+3+SETTLE_CYCLES+3.
- Spike: decayed 0x42100000 (36.0) + weight 0x41200000 (10.0).
  - Required: spike_vec[0]=1, pot_wr_data=0x40C00000 (6.0).
- Full sweep with defaults, weight_valid tied high:
  - exactly 30 pot_wr_en pulses at addresses 0..29 in order;
  - one done pulse at t+213;
  - one clear_adder pulse followed by one set_adder pulse.
- Stall: weight_valid low for 10 cycles at idx 7.
  - Required: weight_ready high throughout the stall; adder inputs stable; done delayed by exactly 10 cycles.
- Ignored start: start pulsed at idx 12.
  - Required: no second clear_adder; sequence unaffected.
- Reset mid-operation: RESET_N low during SETTLE of idx 3.
  - Required: all outputs 0 immediately; IDLE; next start re-runs from idx 0.
